// File: rtl/data_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : data_bus_arbiter_if
// Description : Signal bundle between the two bus masters, the data bus port
//               and the data_bus_arbiter.
//
//   Master N request side (N = 0, 1), driven by the master:
//     mN_req        request, held until mN_ready
//     mN_wr         1 = store, 0 = load
//     mN_size       00 byte, 01 half, 10 word
//     mN_unsigned   zero-extend load
//     mN_addr       byte address  [ADDR_WIDTH]
//     mN_wdata      store data    [DATA_WIDTH]
//   Master N response side, driven by the arbiter:
//     mN_ready      one-cycle completion pulse
//     mN_err        one-cycle timeout pulse, coincident with mN_ready
//     mN_rdata      load data, zero whenever mN_ready is low
//   Data bus side:
//     bus_rd/bus_wd read / write strobes (arbiter -> bus)
//     bus_size, bus_unsigned, bus_addr, bus_wdata  latched fields (arbiter -> bus)
//     bus_rdata     read data (bus -> arbiter)
//     bus_ready     completion (bus -> arbiter)
//   Status (arbiter -> environment):
//     grant         index of current / last owner
//     busy          arbiter not idle
//
//   Modports:
//     slave  : the arbiter's view
//     master : the view of the environment (masters plus bus)
//
// Revision    : 1.0 - initial release
// ============================================================================
interface data_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);

  // Master 0 (core load/store path)
  logic                  m0_req;
  logic                  m0_wr;
  logic [1:0]            m0_size;
  logic                  m0_unsigned;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0] m0_wdata;
  logic                  m0_ready;
  logic                  m0_err;
  logic [DATA_WIDTH-1:0] m0_rdata;

  // Master 1 (loader / debug / DMA)
  logic                  m1_req;
  logic                  m1_wr;
  logic [1:0]            m1_size;
  logic                  m1_unsigned;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic                  m1_ready;
  logic                  m1_err;
  logic [DATA_WIDTH-1:0] m1_rdata;

  // Data bus port
  logic                  bus_rd;
  logic                  bus_wd;
  logic [1:0]            bus_size;
  logic                  bus_unsigned;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic [DATA_WIDTH-1:0] bus_rdata;
  logic                  bus_ready;

  // Status
  logic                  grant;
  logic                  busy;

  modport slave (
    input  m0_req, m0_wr, m0_size, m0_unsigned, m0_addr, m0_wdata,
    output m0_ready, m0_err, m0_rdata,
    input  m1_req, m1_wr, m1_size, m1_unsigned, m1_addr, m1_wdata,
    output m1_ready, m1_err, m1_rdata,
    output bus_rd, bus_wd, bus_size, bus_unsigned, bus_addr, bus_wdata,
    input  bus_rdata, bus_ready,
    output grant, busy
  );

  modport master (
    output m0_req, m0_wr, m0_size, m0_unsigned, m0_addr, m0_wdata,
    input  m0_ready, m0_err, m0_rdata,
    output m1_req, m1_wr, m1_size, m1_unsigned, m1_addr, m1_wdata,
    input  m1_ready, m1_err, m1_rdata,
    input  bus_rd, bus_wd, bus_size, bus_unsigned, bus_addr, bus_wdata,
    output bus_rdata, bus_ready,
    input  grant, busy
  );

endinterface
`default_nettype wire

// File: rtl/data_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_bus_arbiter
// Description : Two-master round-robin arbiter and sequencer for the core's
//               single data bus port. One request is latched at a time, the
//               bus strobes are held until bus_ready or a timeout, and the
//               result is returned to the owning master as a one-cycle
//               ready pulse (with err on timeout).
//
//   Parameters:
//     ADDR_WIDTH  byte address width
//     DATA_WIDTH  data width
//     TIMEOUT     max cycles spent in ACCESS before an error response,
//                 legal range 1..255
//
//   Ports:
//     clk   in   rising-edge clock
//     rst   in   synchronous active-high reset
//     bus   data_bus_arbiter_if.slave - master request/response, data bus
//           strobes and latched fields, grant and busy status
//
//   Latency (no wait states): req sampled in IDLE (cycle 0), strobes in
//   ACCESS (cycle 1), mN_ready in RESP (cycle 2). Every output is either a
//   register or a decode of registered state only.
//
// Revision    : 1.0 - initial release
// ============================================================================
module data_bus_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input wire                clk,
  input wire                rst,
  data_bus_arbiter_if.slave bus
);

  localparam int NUM_M = 2;
  localparam int CNT_W = 8;
  // Counter value on the last permitted ACCESS cycle.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  state_t                state_q,      state_d;
  logic                  owner_q,      owner_d;
  logic                  last_grant_q, last_grant_d;
  logic                  wr_q,         wr_d;
  logic [1:0]            size_q,       size_d;
  logic                  uns_q,        uns_d;
  logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,      wdata_d;
  logic [CNT_W-1:0]      cnt_q,        cnt_d;
  logic                  err_q,        err_d;
  logic [DATA_WIDTH-1:0] rdata_q,      rdata_d;

  // --------------------------------------------------------------------------
  // Master inputs gathered into arrays indexed by master number
  // --------------------------------------------------------------------------
  logic [NUM_M-1:0]                 w_req;
  logic [NUM_M-1:0]                 w_wr;
  logic [NUM_M-1:0][1:0]            w_size;
  logic [NUM_M-1:0]                 w_uns;
  logic [NUM_M-1:0][ADDR_WIDTH-1:0] w_addr;
  logic [NUM_M-1:0][DATA_WIDTH-1:0] w_wdata;

  assign w_req   = {bus.m1_req,      bus.m0_req};
  assign w_wr    = {bus.m1_wr,       bus.m0_wr};
  assign w_size  = {bus.m1_size,     bus.m0_size};
  assign w_uns   = {bus.m1_unsigned, bus.m0_unsigned};
  assign w_addr  = {bus.m1_addr,     bus.m0_addr};
  assign w_wdata = {bus.m1_wdata,    bus.m0_wdata};

  // --------------------------------------------------------------------------
  // Round-robin pick: on a tie the master that did not win last time gets
  // the bus; otherwise the sole requester wins. Only meaningful when |w_req.
  // --------------------------------------------------------------------------
  logic w_pick;
  assign w_pick = (&w_req) ? ~last_grant_q : w_req[1];

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;   // m0 wins the first tie after reset
      wr_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    wr_d         = wr_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    rdata_d      = rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (|w_req) begin
          // Latch the winner's whole request so later changes on its inputs
          // cannot disturb the access in flight.
          owner_d      = w_pick;
          last_grant_d = w_pick;
          wr_d         = w_wr[w_pick];
          size_d       = w_size[w_pick];
          uns_d        = w_uns[w_pick];
          addr_d       = w_addr[w_pick];
          wdata_d      = w_wdata[w_pick];
          cnt_d        = '0;
          err_d        = 1'b0;
          state_d      = S_ACCESS;
        end
      end

      S_ACCESS: begin
        // bus_ready is checked first so a ready on the timeout cycle is a
        // normal completion, not an error.
        if (bus.bus_ready) begin
          rdata_d = wr_q ? '0 : bus.bus_rdata;
          state_d = S_RESP;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Bus-side outputs: strobes decoded from state, fields straight from latches
  // --------------------------------------------------------------------------
  logic w_in_access;
  logic w_in_resp;

  assign w_in_access = (state_q == S_ACCESS);
  assign w_in_resp   = (state_q == S_RESP);

  assign bus.bus_rd       = w_in_access & ~wr_q;
  assign bus.bus_wd       = w_in_access &  wr_q;
  assign bus.bus_size     = size_q;
  assign bus.bus_unsigned = uns_q;
  assign bus.bus_addr     = addr_q;
  assign bus.bus_wdata    = wdata_q;

  assign bus.grant = owner_q;
  assign bus.busy  = (state_q != S_IDLE);

  // --------------------------------------------------------------------------
  // Master-side responses: only the owner sees activity, and read data is
  // forced to zero outside its ready pulse.
  // --------------------------------------------------------------------------
  logic [NUM_M-1:0]                 w_ready;
  logic [NUM_M-1:0]                 w_err;
  logic [NUM_M-1:0][DATA_WIDTH-1:0] w_rdata;

  for (genvar m = 0; m < NUM_M; m++) begin : g_resp
    assign w_ready[m] = w_in_resp & (owner_q == 1'(m));
    assign w_err[m]   = w_ready[m] & err_q;
    assign w_rdata[m] = w_ready[m] ? rdata_q : '0;
  end

  assign bus.m0_ready = w_ready[0];
  assign bus.m0_err   = w_err[0];
  assign bus.m0_rdata = w_rdata[0];
  assign bus.m1_ready = w_ready[1];
  assign bus.m1_err   = w_err[1];
  assign bus.m1_rdata = w_rdata[1];

endmodule
`default_nettype wire

// File: tb/tb_data_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_bus_arbiter
// Description : Randomised self-checking bench for data_bus_arbiter. A
//               transaction-level model tracks pending requests per master,
//               the round-robin owner, the expected ACCESS length and the
//               expected response; outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_bus_arbiter;

  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 32;
  localparam int TIMEOUT    = 15;
  localparam int NUM_TXN    = 400;

  typedef struct packed {
    logic                  wr;
    logic [1:0]            size;
    logic                  uns;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_bus_arbiter_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bif();

  data_bus_arbiter #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .TIMEOUT   (TIMEOUT)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.wr    = 1'($urandom_range(0, 1));
    r.size  = 2'($urandom_range(0, 2));
    r.uns   = 1'($urandom_range(0, 1));
    r.addr  = ADDR_WIDTH'($urandom);
    r.wdata = $urandom;
    return r;
  endfunction

  task automatic drive_master(input int m, input logic req, input req_t r);
    if (m == 0) begin
      bif.m0_req = req; bif.m0_wr = r.wr; bif.m0_size = r.size;
      bif.m0_unsigned = r.uns; bif.m0_addr = r.addr; bif.m0_wdata = r.wdata;
    end else begin
      bif.m1_req = req; bif.m1_wr = r.wr; bif.m1_size = r.size;
      bif.m1_unsigned = r.uns; bif.m1_addr = r.addr; bif.m1_wdata = r.wdata;
    end
  endtask

  function automatic logic get_ready(input int m);
    return (m == 1) ? bif.m1_ready : bif.m0_ready;
  endfunction
  function automatic logic get_err(input int m);
    return (m == 1) ? bif.m1_err : bif.m0_err;
  endfunction
  function automatic logic [DATA_WIDTH-1:0] get_rdata(input int m);
    return (m == 1) ? bif.m1_rdata : bif.m0_rdata;
  endfunction

  // No strobes and no responses on either master.
  task automatic check_quiet(input string tag);
    chk({tag, "_busy"},  64'(bif.busy), 64'd0);
    chk({tag, "_rd"},    64'(bif.bus_rd), 64'd0);
    chk({tag, "_wd"},    64'(bif.bus_wd), 64'd0);
    chk({tag, "_rdy"},   64'({bif.m1_ready, bif.m0_ready}), 64'd0);
    chk({tag, "_err"},   64'({bif.m1_err, bif.m0_err}), 64'd0);
    chk({tag, "_rdata"}, 64'(bif.m0_rdata | bif.m1_rdata), 64'd0);
  endtask

  req_t rq   [2];
  logic pend [2];

  initial begin
    int   last_g;
    int   w;
    int   o;
    int   d;
    logic force_tie;
    logic rst_hit;
    logic exp_err;
    logic [DATA_WIDTH-1:0] rd_val;
    logic [DATA_WIDTH-1:0] exp_rd;

    last_g = 1;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    drive_master(0, 1'b0, '0);
    drive_master(1, 1'b0, '0);
    bif.bus_ready = 1'b0;
    bif.bus_rdata = '0;

    repeat (3) @(negedge clk);
    check_quiet("reset");
    chk("reset_grant", 64'(bif.grant), 64'd0);
    chk("reset_addr",  64'(bif.bus_addr), 64'd0);
    chk("reset_wdata", 64'(bif.bus_wdata), 64'd0);
    chk("reset_size",  64'({bif.bus_size, bif.bus_unsigned}), 64'd0);
    rst = 1'b0;
    force_tie = 1'b1;

    for (int t = 0; t < NUM_TXN; t++) begin
      // Here the DUT is in an IDLE cycle; requests set now are arbitrated
      // at the coming rising edge.
      check_quiet("idle");
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && (force_tie || $urandom_range(0, 7) < 5)) begin
          pend[m] = 1'b1;
          rq[m]   = rand_req();
        end
        drive_master(m, pend[m], pend[m] ? rq[m] : rand_req());
      end
      force_tie = 1'b0;
      bif.bus_ready = 1'b0;
      bif.bus_rdata = $urandom;

      if (!pend[0] && !pend[1]) begin
        @(negedge clk);
        continue;
      end

      // Round robin: a tie goes to the master that did not win last time.
      if (pend[0] && pend[1]) w = 1 - last_g;
      else                    w = pend[1] ? 1 : 0;
      last_g = w;
      o = 1 - w;

      if ($urandom_range(0, 3) == 0) d = TIMEOUT - 1 + $urandom_range(0, 3);
      else                           d = $urandom_range(0, 5);
      rd_val  = $urandom;
      rst_hit = 1'b0;

      for (int i = 0; i <= TIMEOUT; i++) begin
        @(negedge clk);
        chk("acc_busy",  64'(bif.busy), 64'd1);
        chk("acc_grant", 64'(bif.grant), 64'(w));
        chk("acc_rd",    64'(bif.bus_rd), 64'(!rq[w].wr));
        chk("acc_wd",    64'(bif.bus_wd), 64'(rq[w].wr));
        chk("acc_size",  64'({bif.bus_size, bif.bus_unsigned}), 64'({rq[w].size, rq[w].uns}));
        chk("acc_addr",  64'(bif.bus_addr), 64'(rq[w].addr));
        chk("acc_wdata", 64'(bif.bus_wdata), 64'(rq[w].wdata));
        chk("acc_rdy",   64'({bif.m1_ready, bif.m0_ready, bif.m1_err, bif.m0_err}), 64'd0);
        chk("acc_rdata", 64'(bif.m0_rdata | bif.m1_rdata), 64'd0);

        // The owner may change its inputs or drop req; the access continues.
        drive_master(w, 1'($urandom_range(0, 3) != 0), rand_req());
        // The other master may raise a fresh request; it must wait.
        if (!pend[o] && $urandom_range(0, 15) == 0) begin
          pend[o] = 1'b1;
          rq[o]   = rand_req();
          drive_master(o, 1'b1, rq[o]);
        end
        bif.bus_rdata = $urandom;

        if (i < d && i < TIMEOUT - 1 && $urandom_range(0, 39) == 0) begin
          rst = 1'b1;
          bif.bus_ready = 1'b0;
          rst_hit = 1'b1;
          break;
        end
        if (i == d) begin
          bif.bus_ready = 1'b1;
          bif.bus_rdata = rd_val;
          break;
        end
        bif.bus_ready = 1'b0;
        if (i == TIMEOUT - 1) break;
      end

      if (rst_hit) begin
        // Access discarded; the owner still wants its transfer.
        @(negedge clk);
        check_quiet("rst");
        chk("rst_grant", 64'(bif.grant), 64'd0);
        rst = 1'b0;
        last_g = 1;
        force_tie = 1'b1;
        continue;
      end

      @(negedge clk);
      exp_err = (d >= TIMEOUT);
      exp_rd  = (rq[w].wr || exp_err) ? '0 : rd_val;
      chk("resp_rdy",       64'(get_ready(w)), 64'd1);
      chk("resp_err",       64'(get_err(w)), 64'(exp_err));
      chk("resp_rdata",     64'(get_rdata(w)), 64'(exp_rd));
      chk("resp_other_rdy", 64'({get_ready(o), get_err(o)}), 64'd0);
      chk("resp_other_rd",  64'(get_rdata(o)), 64'd0);
      chk("resp_strobe",    64'({bif.bus_rd, bif.bus_wd}), 64'd0);
      chk("resp_busy",      64'(bif.busy), 64'd1);
      chk("resp_grant",     64'(bif.grant), 64'(w));

      bif.bus_ready = 1'b0;
      pend[w] = 1'b0;
      drive_master(w, 1'b0, rand_req());
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
